serial_rx_ctrl: RTL

- Sequencing controller for the serial-port receive path.
- Consumes the one-cycle falling-edge pulse from the high-to-low detector on the receive line and runs the frame state machine: start-bit qualification, mid-bit sampling of data bits, and stop-bit check.
- Delivers each received byte with a one-cycle valid strobe, or flags a framing error.
- Sits between the line synchronizer/edge detector and the receive buffer.

---
 rtl/serial_rx_ctrl.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/serial_rx_ctrl.sv
// Receive-path sequencer: qualifies the start bit, samples data bits mid-bit,
// checks the stop bit and delivers the byte or a framing-error pulse.
module serial_rx_ctrl #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rxd,
   input  logic                 startEdge,
   output logic [DATA_BITS-1:0] rxData,
   output logic                 rxValid,
   output logic                 frameError,
   output logic                 busy,
   output logic                 sampleTick
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;

   localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DATA_BITS - 1);

   state_t                state_q, state_d;
   logic [BAUD_W-1:0]     baud_cnt_q, baud_cnt_d;
   logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
   logic [DATA_BITS-1:0]  shift_q, shift_d;
   logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
   logic                  rx_valid_q, rx_valid_d;
   logic                  frame_error_q, frame_error_d;
   logic                  busy_q, busy_d;
   logic                  sample_tick;

   always_comb begin
      state_d       = state_q;
      baud_cnt_d    = baud_cnt_q;
      bit_idx_d     = bit_idx_q;
      shift_d       = shift_q;
      rx_data_d     = rx_data_q;
      rx_valid_d    = 1'b0;
      frame_error_d = 1'b0;
      sample_tick   = 1'b0;

      case (state_q)
         S_IDLE: begin
            // rxd is deliberately ignored here; only the edge pulse starts a frame
            if (startEdge) begin
               state_d    = S_START;
               baud_cnt_d = '0;
            end
         end

         S_START: begin
            if (baud_cnt_q == HALF_LAST) begin
               sample_tick = 1'b1;
               baud_cnt_d  = '0;
               if (!rxd) begin
                  state_d   = S_DATA;
                  bit_idx_d = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         S_DATA: begin
            if (baud_cnt_q == BIT_LAST) begin
               sample_tick         = 1'b1;
               baud_cnt_d          = '0;
               shift_d[bit_idx_q]  = rxd;
               if (bit_idx_q == IDX_LAST) begin
                  state_d = S_STOP;
               end else begin
                  bit_idx_d = bit_idx_q + 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         S_STOP: begin
            if (baud_cnt_q == BIT_LAST) begin
               sample_tick = 1'b1;
               baud_cnt_d  = '0;
               state_d     = S_IDLE;
               if (rxd) begin
                  rx_data_d  = shift_q;
                  rx_valid_d = 1'b1;
               end else begin
                  frame_error_d = 1'b1;
               end
            end else begin
               baud_cnt_d = baud_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= S_IDLE;
         baud_cnt_q    <= '0;
         bit_idx_q     <= '0;
         shift_q       <= '0;
         rx_data_q     <= '0;
         rx_valid_q    <= 1'b0;
         frame_error_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         baud_cnt_q    <= baud_cnt_d;
         bit_idx_q     <= bit_idx_d;
         shift_q       <= shift_d;
         rx_data_q     <= rx_data_d;
         rx_valid_q    <= rx_valid_d;
         frame_error_q <= frame_error_d;
         busy_q        <= busy_d;
      end
   end

   assign rxData     = rx_data_q;
   assign rxValid    = rx_valid_q;
   assign frameError = frame_error_q;
   assign busy       = busy_q;
   assign sampleTick = sample_tick;

endmodule
